// File: rtl/reg_file_mp.sv
// reg_file_mp: multi-port register file with two write ports, NUM_RD
// registered read ports with write-to-read bypass, and a sequential clear
// sweep that zeroes one address per cycle.
// Optional feature: define REG_FILE_MP_ZERO_R0_EN to hardwire register 0 to
// zero (writes to address 0 dropped, reads and bypass of address 0 return 0).
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | normal operation; clr_i starts a sweep
// ST_SWEEP | zeroing address r_cnt each cycle; writes blocked, reads give 0
module reg_file_mp #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_RD     = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [NUM_RD-1:0]            rd_en_i,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] raddr_i,
  output logic [NUM_RD*DATA_WIDTH-1:0] rdata_o,
  input  logic                         wa_en_i,
  input  logic [ADDR_WIDTH-1:0]        wa_addr_i,
  input  logic [DATA_WIDTH-1:0]        wa_data_i,
  input  logic                         wb_en_i,
  input  logic [ADDR_WIDTH-1:0]        wb_addr_i,
  input  logic [DATA_WIDTH-1:0]        wb_data_i,
  input  logic                         clr_i,
  output logic                         busy_o
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } state_t;

  state_t                  r_state;
  logic [ADDR_WIDTH-1:0]   r_cnt;
  logic                    r_busy;
  logic [DATA_WIDTH-1:0]   r_mem [DEPTH];

  logic                    w_r0_zero;
  logic                    w_wa_commit;
  logic                    w_wb_commit;

`ifdef REG_FILE_MP_ZERO_R0_EN
  assign w_r0_zero = 1'b1;
`else
  assign w_r0_zero = 1'b0;
`endif

  // A write commits only outside the sweep and never to a hardwired-zero r0
  assign w_wa_commit = wa_en_i && !r_busy && !(w_r0_zero && (wa_addr_i == '0));
  assign w_wb_commit = wb_en_i && !r_busy && !(w_r0_zero && (wb_addr_i == '0));

  assign busy_o = r_busy;

  // Clear-sweep FSM: counter walks 0..DEPTH-1 once, busy registered with state
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (clr_i) begin
            r_state <= ST_SWEEP;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end
        end
        ST_SWEEP: begin
          if (r_cnt == LAST_ADDR) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Storage: sweep zeroing has priority; port B is applied last so it wins
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (r_state == ST_SWEEP) begin
      r_mem[r_cnt] <= '0;
    end else begin
      if (w_wa_commit) r_mem[wa_addr_i] <= wa_data_i;
      if (w_wb_commit) r_mem[wb_addr_i] <= wb_data_i;
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [ADDR_WIDTH-1:0] w_raddr;
    logic [DATA_WIDTH-1:0] r_rdata;

    assign w_raddr = raddr_i[p*ADDR_WIDTH +: ADDR_WIDTH];
    assign rdata_o[p*DATA_WIDTH +: DATA_WIDTH] = r_rdata;

    // Registered read with same-cycle write bypass (B over A); holds when disabled
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        r_rdata <= '0;
      end else if (rd_en_i[p]) begin
        if (r_busy)
          r_rdata <= '0;
        else if (w_wb_commit && (wb_addr_i == w_raddr))
          r_rdata <= wb_data_i;
        else if (w_wa_commit && (wa_addr_i == w_raddr))
          r_rdata <= wa_data_i;
        else if (w_r0_zero && (w_raddr == '0))
          r_rdata <= '0;
        else
          r_rdata <= r_mem[w_raddr];
      end
    end
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// tb_reg_file_mp: directed stimulus against a behavioural model of reg_file_mp.
module tb_reg_file_mp;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int NR    = 2;
  localparam int DEPTH = 2 ** AW;

  logic               clk_i = 1'b0;
  logic               rst_i = 1'b1;
  logic [NR-1:0]      rd_en_i = '0;
  logic [NR*AW-1:0]   raddr_i = '0;
  logic [NR*DW-1:0]   rdata_o;
  logic               wa_en_i = 1'b0;
  logic [AW-1:0]      wa_addr_i = '0;
  logic [DW-1:0]      wa_data_i = '0;
  logic               wb_en_i = 1'b0;
  logic [AW-1:0]      wb_addr_i = '0;
  logic [DW-1:0]      wb_data_i = '0;
  logic               clr_i = 1'b0;
  logic               busy_o;

  int tests = 0;
  int fails = 0;

  reg_file_mp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_RD(NR)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .rd_en_i(rd_en_i), .raddr_i(raddr_i), .rdata_o(rdata_o),
    .wa_en_i(wa_en_i), .wa_addr_i(wa_addr_i), .wa_data_i(wa_data_i),
    .wb_en_i(wb_en_i), .wb_addr_i(wb_addr_i), .wb_data_i(wb_data_i),
    .clr_i(clr_i), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

`ifdef REG_FILE_MP_ZERO_R0_EN
  localparam bit ZERO_R0 = 1'b1;
`else
  localparam bit ZERO_R0 = 1'b0;
`endif

  // Behavioural model: a read returns the contents as they stand after this
  // edge's writes; a sweep is a countdown of remaining addresses to zero.
  logic [DW-1:0] m_mem [DEPTH];
  logic [DW-1:0] m_rd  [NR];
  int            m_left = 0;

  function automatic void m_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (!(ZERO_R0 && a == 0)) m_mem[a] = d;
  endfunction

  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
      for (int p = 0; p < NR; p++) m_rd[p] = '0;
      m_left = 0;
    end else begin
      automatic bit sweeping = (m_left > 0);
      if (!sweeping) begin
        if (wa_en_i) m_write(wa_addr_i, wa_data_i);
        if (wb_en_i) m_write(wb_addr_i, wb_data_i);
      end
      for (int p = 0; p < NR; p++)
        if (rd_en_i[p]) m_rd[p] = sweeping ? '0 : m_mem[raddr_i[p*AW +: AW]];
      if (sweeping) begin
        m_mem[DEPTH - m_left] = '0;
        m_left--;
      end else if (clr_i) begin
        m_left = DEPTH;
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Every cycle compare against the model
  always @(negedge clk_i) begin
    for (int p = 0; p < NR; p++)
      chk($sformatf("model_rdata%0d", p), 64'(rdata_o[p*DW +: DW]), 64'(m_rd[p]));
    chk("model_busy", 64'(busy_o), 64'(m_left > 0));
  end

  task automatic idle();
    rd_en_i = '0; wa_en_i = 1'b0; wb_en_i = 1'b0; clr_i = 1'b0;
  endtask

  task automatic tick();
    @(negedge clk_i);
  endtask

  task automatic rd(input int p, input int a);
    rd_en_i[p] = 1'b1;
    raddr_i[p*AW +: AW] = AW'(a);
  endtask

  task automatic wa(input int a, input logic [DW-1:0] d);
    wa_en_i = 1'b1; wa_addr_i = AW'(a); wa_data_i = d;
  endtask

  task automatic wb(input int a, input logic [DW-1:0] d);
    wb_en_i = 1'b1; wb_addr_i = AW'(a); wb_data_i = d;
  endtask

  function automatic logic [DW-1:0] port(input int p);
    return rdata_o[p*DW +: DW];
  endfunction

  initial begin
    int n;
    logic [DW-1:0] exp0;

    repeat (3) tick();
    chk("reset_rdata0", 64'(port(0)), 64'h0);
    chk("reset_rdata1", 64'(port(1)), 64'h0);
    chk("reset_busy", 64'(busy_o), 64'h0);
    rst_i = 1'b0;

    // First edge after release: write honoured
    wa(3, 32'hDEADBEEF); tick(); idle();
    rd(0, 3); tick(); idle();
    chk("rd_addr3", 64'(port(0)), 64'hDEADBEEF);

    // Same-address dual write with bypass to port 1
    wa(7, 32'h11); wb(7, 32'h22); rd(1, 7); tick(); idle();
    chk("bypass_b_over_a", 64'(port(1)), 64'h22);
    rd(0, 7); rd(1, 3); tick(); idle();
    chk("stored_b_over_a", 64'(port(0)), 64'h22);
    chk("port1_addr3", 64'(port(1)), 64'hDEADBEEF);

    // Both ports same address
    rd(0, 3); rd(1, 3); tick(); idle();
    chk("same_addr_p0", 64'(port(0)), 64'hDEADBEEF);
    chk("same_addr_p1", 64'(port(1)), 64'hDEADBEEF);

    // Hold when read disabled
    wa(5, 32'h55); rd(0, 5); tick(); idle();
    chk("bypass_a", 64'(port(0)), 64'h55);
    for (int i = 0; i < 3; i++) begin
      raddr_i[0 +: AW] = AW'(i + 6);
      tick();
      chk("hold_p0", 64'(port(0)), 64'h55);
    end

    // Register 0 behaviour
    exp0 = ZERO_R0 ? 32'h0 : 32'hFFFF_FFFF;
    wa(0, 32'hFFFF_FFFF); rd(1, 0); tick(); idle();
    chk("r0_bypass", 64'(port(1)), 64'(exp0));
    rd(0, 0); tick(); idle();
    chk("r0_read", 64'(port(0)), 64'(exp0));

    // Fill, then sweep with a second clr and a write mid-sweep
    for (int i = 0; i < DEPTH / 2; i++) begin
      wa(2 * i, DW'(i + 1)); wb(2 * i + 1, DW'(32'h100 + i)); tick();
    end
    idle();
    rd(0, 1); tick(); idle();
    chk("filled_addr1", 64'(port(0)), 64'h100);
    clr_i = 1'b1; tick(); idle();
    n = 0;
    while (busy_o && n < 100) begin
      n++;
      if (n == 4) clr_i = 1'b1;
      if (n == 8) wa(2, 32'hAB);
      if (n == 12) rd(1, 1);
      tick(); idle();
      if (n == 12) chk("read_during_sweep", 64'(port(1)), 64'h0);
    end
    chk("sweep_busy_cycles", 64'(n), 64'(DEPTH));
    for (int i = 0; i < DEPTH / 2; i++) begin
      rd(0, 2 * i); rd(1, 2 * i + 1); tick();
      chk("post_sweep_p0", 64'(port(0)), 64'h0);
      chk("post_sweep_p1", 64'(port(1)), 64'h0);
    end
    idle();

    // Reset during sweep, then normal operation
    wa(4, 32'h44); tick(); idle();
    rd(0, 4); tick(); idle();
    chk("pre_abort_addr4", 64'(port(0)), 64'h44);
    clr_i = 1'b1; tick(); idle();
    repeat (9) tick();
    chk("busy_mid_sweep", 64'(busy_o), 64'h1);
    #2 rst_i = 1'b1;
    #1;
    chk("abort_busy", 64'(busy_o), 64'h0);
    chk("abort_rdata0", 64'(port(0)), 64'h0);
    chk("abort_rdata1", 64'(port(1)), 64'h0);
    tick();
    rst_i = 1'b0;
    wa(9, 32'h99); tick(); idle();
    rd(0, 9); rd(1, 4); tick(); idle();
    chk("after_abort_addr9", 64'(port(0)), 64'h99);
    chk("after_abort_addr4", 64'(port(1)), 64'h0);
    chk("after_abort_busy", 64'(busy_o), 64'h0);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
